// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - single-outstanding command issuer in front of an external combinational ALU
module alu_issuer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_sel,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [2:0]       alu_sel,
   input  logic [3:0]       alu_out,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_out,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   div_zero;

   // Division and modulo by zero are answered locally without using the ALU.
   assign div_zero = ((cmd_sel == 3'b010) || (cmd_sel == 3'b011)) && (cmd_b == 4'd0);
   assign accept   = cmd_valid && cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = div_zero ? RESP : ISSUE;
         end
         ISSUE: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a     <= 4'd0;
         alu_b     <= 4'd0;
         alu_sel   <= 3'b000;
         rsp_out   <= 4'd0;
         rsp_carry <= 1'b0;
         rsp_err   <= 1'b0;
         op_count  <= '0;
      end else begin
         if (accept) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            if (div_zero) begin
               rsp_out   <= 4'd0;
               rsp_carry <= 1'b0;
               rsp_err   <= 1'b1;
            end
         end
         if (state == ISSUE) begin
            rsp_out   <= alu_out;
            rsp_err   <= 1'b0;
            // Carry only means something for add and sub.
            rsp_carry <= (alu_sel[2:1] == 2'b00) ? alu_carry : 1'b0;
         end
         if ((state == RESP) && rsp_ready) op_count <= op_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - directed self-checking bench for alu_issuer with a behavioural ALU
module tb_alu_issuer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_sel;
   logic [3:0] cmd_a, cmd_b;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_out;
   logic       alu_carry;
   logic       rsp_valid, rsp_ready;
   logic [3:0] rsp_out;
   logic       rsp_carry, rsp_err;
   logic [1:0] op_count;
   logic       force_c;

   int total = 0;
   int bad   = 0;

   alu_issuer #(.CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Reference ALU; force_c pins the carry high to exercise masking.
   always_comb begin
      logic [4:0] wide;
      wide      = 5'd0;
      alu_out   = 4'd0;
      alu_carry = 1'b0;
      case (alu_sel)
         3'b000: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = wide[3:0]; alu_carry = wide[4]; end
         3'b001: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = wide[3:0]; alu_carry = wide[4]; end
         3'b010: alu_out = (alu_b == 4'd0) ? 4'd0 : alu_a / alu_b;
         3'b011: alu_out = (alu_b == 4'd0) ? 4'd0 : alu_a % alu_b;
         3'b100: alu_out = alu_a | alu_b;
         3'b101: alu_out = alu_a & alu_b;
         3'b110: alu_out = alu_a ^ alu_b;
         default: alu_out = ~alu_a;
      endcase
      if (force_c) alu_carry = 1'b1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
      cmd_sel   = s;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 3'b000; cmd_a = 4'd0; cmd_b = 4'd0;
      rsp_ready = 1'b1; force_c = 1'b0;
      #1;
      check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
      check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
      check("rst_payload", {rsp_out, rsp_carry, rsp_err, 2'b00}, 8'h00);
      check("rst_alu", {alu_a, alu_b}, 8'h00);
      check("rst_alu_sel", {5'd0, alu_sel}, 8'd0);
      check("rst_count", {6'd0, op_count}, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // Add with carry: 9 + 8 = 0x11
      send(3'b000, 4'd9, 4'd8);
      check("add_issue_ready", {7'd0, cmd_ready}, 8'd0);
      check("add_issue_valid", {7'd0, rsp_valid}, 8'd0);
      check("add_alu_drive", {alu_a, alu_b}, 8'h98);
      step();
      check("add_valid", {7'd0, rsp_valid}, 8'd1);
      check("add_payload", {rsp_out, rsp_carry, rsp_err, 2'b00}, {4'h1, 1'b1, 1'b0, 2'b00});
      check("add_count_before", {6'd0, op_count}, 8'd0);
      step();
      check("add_done_valid", {7'd0, rsp_valid}, 8'd0);
      check("add_done_ready", {7'd0, cmd_ready}, 8'd1);
      check("add_count", {6'd0, op_count}, 8'd1);

      // Divide by zero skips the ISSUE cycle
      send(3'b010, 4'd7, 4'd0);
      check("dz_valid", {7'd0, rsp_valid}, 8'd1);
      check("dz_payload", {rsp_out, rsp_carry, rsp_err, 2'b00}, {4'h0, 1'b0, 1'b1, 2'b00});
      step();
      check("dz_count", {6'd0, op_count}, 8'd2);
      check("dz_ready", {7'd0, cmd_ready}, 8'd1);

      // Backpressure: xor A^6 = C held while rsp_ready low, extra commands ignored
      rsp_ready = 1'b0;
      send(3'b110, 4'hA, 4'h6);
      step();
      cmd_sel = 3'b000; cmd_a = 4'd1; cmd_b = 4'd1; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {7'd0, rsp_valid}, 8'd1);
         check("bp_payload", {rsp_out, rsp_carry, rsp_err, 2'b00}, {4'hC, 1'b0, 1'b0, 2'b00});
         check("bp_cmd_ready", {7'd0, cmd_ready}, 8'd0);
         check("bp_alu_hold", {alu_a, alu_b}, 8'hA6);
         step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      check("bp_release_valid", {7'd0, rsp_valid}, 8'd0);
      check("bp_release_ready", {7'd0, cmd_ready}, 8'd1);
      check("bp_count", {6'd0, op_count}, 8'd3);
      check("bp_idle_alu_hold", {5'd0, alu_sel}, 8'd6);

      // And with forced carry: carry masked; fourth op wraps the 2-bit counter
      force_c = 1'b1;
      send(3'b101, 4'hF, 4'h3);
      step();
      check("and_payload", {rsp_out, rsp_carry, rsp_err, 2'b00}, {4'h3, 1'b0, 1'b0, 2'b00});
      step();
      check("wrap_count", {6'd0, op_count}, 8'd0);
      force_c = 1'b0;

      // Sub with borrow: 3 - 5 = 0xE, carry 1
      send(3'b001, 4'd3, 4'd5);
      step();
      check("sub_payload", {rsp_out, rsp_carry, rsp_err, 2'b00}, {4'hE, 1'b1, 1'b0, 2'b00});
      step();
      check("sub_count", {6'd0, op_count}, 8'd1);

      // Reset between edges while in ISSUE
      send(3'b000, 4'd1, 4'd2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", {7'd0, rsp_valid}, 8'd0);
      check("mid_rst_ready", {7'd0, cmd_ready}, 8'd1);
      check("mid_rst_alu", {alu_a, alu_b}, 8'h00);
      check("mid_rst_count", {6'd0, op_count}, 8'd0);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_valid", {7'd0, rsp_valid}, 8'd0);
         check("post_rst_count", {6'd0, op_count}, 8'd0);
      end

      // Normal operation after reset: or 5|A = F
      send(3'b100, 4'h5, 4'hA);
      step();
      check("or_payload", {rsp_out, rsp_carry, rsp_err, 2'b00}, {4'hF, 1'b0, 1'b0, 2'b00});
      step();
      check("or_count", {6'd0, op_count}, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
